// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master and its SCLK tick generator.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } spi_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK half-period timer: one-cycle tick every CLK_DIV clk cycles while enabled,
// restarted from zero whenever a new frame is accepted.
module spi_clkgen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CNT_W = clog2_min1(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_master.sv
// SPI master: one word per valid/ready handshake, MSB first, any CPOL/CPHA mode,
// full-duplex capture of miso and one-of-NUM_CS active-low chip select.
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2,
   parameter int NUM_CS  = 1,
   parameter int CS_GAP  = 1,
   localparam int CS_W   = clog2_min1(NUM_CS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [CS_W-1:0]   tx_cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int EDGE_W = $clog2(2 * DATA_W + 1);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
   localparam int GAP_W = clog2_min1(CS_GAP);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   spi_state_e        state_q;
   spi_mode_t         mode_q;
   logic [DATA_W-1:0] tx_q;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              rx_valid_q;
   logic [EDGE_W-1:0] edge_q;
   logic [GAP_W-1:0]  gap_q;
   logic              sclk_q;
   logic              mosi_q;
   logic [NUM_CS-1:0] cs_n_q;

   logic              accept;
   logic              tick;
   logic              lead_edge;
   logic              final_edge;
   logic              drive_edge;
   logic              sample_edge;
   logic [NUM_CS-1:0] cs_dec;

   assign accept = (state_q == IDLE) && tx_valid;

   // Out-of-range selects leave every bit high; the frame still runs.
   for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_dec[gi] = (tx_cs_sel != CS_W'(gi));
   end

   spi_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (accept),
      .en_i   (state_q inside {SETUP, SHIFT, HOLD}),
      .tick_o (tick)
   );

   // edge_q counts edges already produced, so the upcoming edge is odd (leading) when it is even.
   assign lead_edge   = ~edge_q[0];
   assign final_edge  = (edge_q == LAST_EDGE);
   assign drive_edge  = mode_q.cpha ? lead_edge : (~lead_edge && ~final_edge);
   assign sample_edge = mode_q.cpha ? ~lead_edge : lead_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mode_q     <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         edge_q     <= '0;
         gap_q      <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               sclk_q <= cpol;
               if (tx_valid) begin
                  mode_q  <= '{cpol: cpol, cpha: cpha};
                  cs_n_q  <= cs_dec;
                  edge_q  <= '0;
                  rx_q    <= '0;
                  state_q <= SETUP;
                  // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on edge 1.
                  if (!cpha) begin
                     mosi_q <= tx_data[DATA_W-1];
                     tx_q   <= {tx_data[DATA_W-2:0], 1'b0};
                  end else begin
                     tx_q   <= tx_data;
                  end
               end
            end
            SETUP, SHIFT: begin
               if (tick) begin
                  sclk_q  <= ~sclk_q;
                  edge_q  <= edge_q + EDGE_W'(1);
                  state_q <= final_edge ? HOLD : SHIFT;
                  if (drive_edge) begin
                     mosi_q <= tx_q[DATA_W-1];
                     tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                  end
                  if (sample_edge) begin
                     rx_q <= {rx_q[DATA_W-2:0], miso};
                  end
               end
            end
            HOLD: begin
               sclk_q <= mode_q.cpol;
               if (tick) begin
                  cs_n_q     <= '1;
                  rx_data_q  <= rx_q;
                  rx_valid_q <= 1'b1;
                  gap_q      <= '0;
                  state_q    <= GAP;
               end
            end
            GAP: begin
               sclk_q <= mode_q.cpol;
               if (gap_q == GAP_LAST) begin
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q + GAP_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_ready = (state_q == IDLE);
   assign busy     = ~tx_ready;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: an 8-bit/CLK_DIV=2/4-CS instance with a mode-aware
// slave model, and a 16-bit/CLK_DIV=1/3-CS instance with miso looped back to mosi.
`timescale 1ns/1ps
module tb_spi_master;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // ---- instance 0 ----
   logic       tx_valid0 = 1'b0;
   logic       tx_ready0;
   logic [7:0] tx_data0 = '0;
   logic [1:0] tx_sel0 = '0;
   logic       cpol0 = 1'b0;
   logic       cpha0 = 1'b0;
   logic [7:0] rx_data0;
   logic       rx_valid0;
   logic       busy0;
   logic       sclk0;
   logic       mosi0;
   logic       miso0;
   logic [3:0] cs_n0;
   logic       loop0 = 1'b1;
   logic [7:0] slave_word = '0;
   logic [7:0] exp0_q[$];

   // ---- instance 1 ----
   logic        tx_valid1 = 1'b0;
   logic        tx_ready1;
   logic [15:0] tx_data1 = '0;
   logic [1:0]  tx_sel1 = '0;
   logic        cpol1 = 1'b0;
   logic        cpha1 = 1'b0;
   logic [15:0] rx_data1;
   logic        rx_valid1;
   logic        busy1;
   logic        sclk1;
   logic        mosi1;
   logic        miso1;
   logic [2:0]  cs_n1;
   logic [15:0] exp1_q[$];

   spi_master #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4), .CS_GAP(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
      .tx_data(tx_data0), .tx_cs_sel(tx_sel0), .cpol(cpol0), .cpha(cpha0),
      .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0), .sclk(sclk0),
      .mosi(mosi0), .miso(miso0), .cs_n(cs_n0)
   );

   spi_master #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(3), .CS_GAP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
      .tx_data(tx_data1), .tx_cs_sel(tx_sel1), .cpol(cpol1), .cpha(cpha1),
      .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .sclk(sclk1),
      .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
   );

   assign miso1 = mosi1;

   // Slave model: counts SCLK edges while selected and presents the bit the mode calls for.
   int   sl_edges = 0;
   int   sl_idx;
   logic sclk_prev = 1'b0;
   always @(sclk0 or cs_n0) begin
      if (&cs_n0) sl_edges = 0;
      else if (sclk0 !== sclk_prev) sl_edges = sl_edges + 1;
      sclk_prev = sclk0;
   end
   always_comb begin
      sl_idx = 0;
      if (cpha0) sl_idx = (sl_edges == 0) ? 0 : (sl_edges - 1) / 2;
      else       sl_idx = sl_edges / 2;
      if (sl_idx > 7) sl_idx = 7;
   end
   assign miso0 = loop0 ? mosi0 : slave_word[3'(7 - sl_idx)];

   int tog1 = 0;
   logic sclk1_prev = 1'b0;
   always @(negedge clk) begin
      if (sclk1 !== sclk1_prev) tog1 <= tog1 + 1;
      sclk1_prev <= sclk1;
   end

   task automatic test_reset();
      cpol0 = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (sclk0 !== 1'b0) begin n_bad++; $display("FAIL reset_sclk got=%b exp=0", sclk0); end
      n_cmp++; if (mosi0 !== 1'b0) begin n_bad++; $display("FAIL reset_mosi got=%b exp=0", mosi0); end
      n_cmp++; if (cs_n0 !== 4'hF) begin n_bad++; $display("FAIL reset_cs_n got=%h exp=f", cs_n0); end
      n_cmp++; if (tx_ready0 !== 1'b1 || busy0 !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready got=%b/%b exp=1/0", tx_ready0, busy0);
      end
      n_cmp++; if (rx_valid0 !== 1'b0 || rx_data0 !== 8'h00) begin
         n_bad++; $display("FAIL reset_rx got=%b/%h exp=0/00", rx_valid0, rx_data0);
      end
      n_cmp++; if (cs_n1 !== 3'h7 || rx_data1 !== 16'h0) begin
         n_bad++; $display("FAIL reset_dut1 got=%h/%h exp=7/0000", cs_n1, rx_data1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      $display("[%0t] reset released", $time);
   endtask

   task automatic test_mode0();
      int t0, rxv_c, rdy_c, tog;
      logic prev;
      logic [7:0] exp;
      loop0 = 1'b1; cpol0 = 1'b0; cpha0 = 1'b0; tx_sel0 = 2'd0;
      repeat (2) @(negedge clk);
      tx_data0 = 8'hA5; tx_valid0 = 1'b1; t0 = cyc; exp0_q.push_back(8'hA5);
      rxv_c = -1; rdy_c = -1; tog = 0; prev = sclk0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (c == 0) begin
            tx_valid0 = 1'b0;
            n_cmp++; if (cs_n0 !== 4'b1110) begin n_bad++; $display("FAIL m0_cs_low got=%b exp=1110", cs_n0); end
         end
         if (sclk0 !== prev) tog++;
         prev = sclk0;
         if (rx_valid0) begin
            rxv_c = cyc - t0;
            n_cmp++;
            if (exp0_q.size() == 0) begin n_bad++; $display("FAIL m0_rx unexpected got=%h", rx_data0); end
            else begin
               exp = exp0_q.pop_front();
               $display("[%0t] mode0 rx=%h exp=%h", $time, rx_data0, exp);
               if (rx_data0 !== exp) begin n_bad++; $display("FAIL m0_rx got=%h exp=%h", rx_data0, exp); end
            end
         end
         if (tx_ready0) begin rdy_c = cyc - t0; break; end
      end
      n_cmp++; if (rxv_c !== 35) begin n_bad++; $display("FAIL m0_rxv_time got=%0d exp=35", rxv_c); end
      n_cmp++; if (rdy_c !== 36) begin n_bad++; $display("FAIL m0_ready_time got=%0d exp=36", rdy_c); end
      n_cmp++; if (tog !== 16) begin n_bad++; $display("FAIL m0_toggles got=%0d exp=16", tog); end
   endtask

   task automatic test_modes();
      int tog;
      logic prev, done;
      logic [7:0] exp;
      for (int m = 1; m < 4; m++) begin
         loop0 = 1'b0; slave_word = 8'h3C; cpol0 = m[1]; cpha0 = m[0]; tx_sel0 = 2'd0;
         repeat (2) @(negedge clk);
         n_cmp++; if (sclk0 !== cpol0) begin n_bad++; $display("FAIL mode%0d_idle_sclk got=%b exp=%b", m, sclk0, cpol0); end
         tx_data0 = 8'hC3; tx_valid0 = 1'b1; exp0_q.push_back(8'h3C);
         tog = 0; prev = sclk0; done = 1'b0;
         for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            tx_valid0 = 1'b0;
            if (sclk0 !== prev) tog++;
            prev = sclk0;
            if (rx_valid0) begin
               n_cmp++;
               if (exp0_q.size() == 0) begin n_bad++; $display("FAIL mode%0d_rx unexpected got=%h", m, rx_data0); end
               else begin
                  exp = exp0_q.pop_front();
                  $display("[%0t] mode%0d rx=%h exp=%h", $time, m, rx_data0, exp);
                  if (rx_data0 !== exp) begin n_bad++; $display("FAIL mode%0d_rx got=%h exp=%h", m, rx_data0, exp); end
               end
            end
            if (tx_ready0) begin done = 1'b1; break; end
         end
         n_cmp++; if (done !== 1'b1 || tog !== 16) begin
            n_bad++; $display("FAIL mode%0d_toggles got=%0d done=%b exp=16", m, tog, done);
         end
         n_cmp++; if (sclk0 !== cpol0) begin n_bad++; $display("FAIL mode%0d_end_sclk got=%b exp=%b", m, sclk0, cpol0); end
      end
   endtask

   task automatic test_cs_sel();
      int bad_cs;
      logic done;
      logic [7:0] exp;
      loop0 = 1'b1; cpol0 = 1'b0; cpha0 = 1'b0; tx_sel0 = 2'd2;
      repeat (2) @(negedge clk);
      tx_data0 = 8'h5A; tx_valid0 = 1'b1; exp0_q.push_back(8'h5A);
      bad_cs = 0; done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         tx_valid0 = 1'b0;
         if (c == 0) begin
            n_cmp++; if (cs_n0 !== 4'b1011) begin n_bad++; $display("FAIL cs2_low got=%b exp=1011", cs_n0); end
         end
         if (cs_n0 !== 4'b1011 && cs_n0 !== 4'b1111) bad_cs++;
         if (rx_valid0) begin
            n_cmp++;
            if (exp0_q.size() == 0) begin n_bad++; $display("FAIL cs2_rx unexpected got=%h", rx_data0); end
            else begin
               exp = exp0_q.pop_front();
               $display("[%0t] cs2 rx=%h exp=%h", $time, rx_data0, exp);
               if (rx_data0 !== exp) begin n_bad++; $display("FAIL cs2_rx got=%h exp=%h", rx_data0, exp); end
            end
         end
         if (tx_ready0) begin done = 1'b1; break; end
      end
      n_cmp++; if (done !== 1'b1 || bad_cs !== 0) begin
         n_bad++; $display("FAIL cs2_only got=%0d stray cycles done=%b exp=0", bad_cs, done);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [3];
      int acc_cyc [3];
      int n_acc, n_rx, gap_cyc;
      logic pending;
      logic [7:0] exp;
      words = '{8'h11, 8'h22, 8'h33};
      loop0 = 1'b1; cpol0 = 1'b0; cpha0 = 1'b0; tx_sel0 = 2'd1;
      repeat (2) @(negedge clk);
      tx_data0 = words[0]; tx_valid0 = 1'b1; exp0_q.push_back(words[0]);
      acc_cyc[0] = cyc; n_acc = 1; pending = 1'b1; n_rx = 0; gap_cyc = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (pending) begin
            if (n_acc < 3) begin tx_data0 = words[n_acc]; exp0_q.push_back(words[n_acc]); end
            else tx_valid0 = 1'b0;
         end
         if (cs_n0 === 4'hF && busy0) gap_cyc++;
         if (rx_valid0) begin
            n_rx++; n_cmp++;
            if (exp0_q.size() == 0) begin n_bad++; $display("FAIL b2b_rx unexpected got=%h", rx_data0); end
            else begin
               exp = exp0_q.pop_front();
               $display("[%0t] b2b rx=%h exp=%h", $time, rx_data0, exp);
               if (rx_data0 !== exp) begin n_bad++; $display("FAIL b2b_rx got=%h exp=%h", rx_data0, exp); end
            end
         end
         pending = tx_valid0 && tx_ready0;
         if (pending && n_acc < 3) begin acc_cyc[n_acc] = cyc; n_acc++; end
         if (n_rx == 3 && tx_ready0 && !tx_valid0) break;
      end
      tx_valid0 = 1'b0;
      n_cmp++; if (n_acc !== 3 || n_rx !== 3) begin
         n_bad++; $display("FAIL b2b_count got=%0d acc %0d rx exp=3/3", n_acc, n_rx);
      end else begin
         n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 36 || acc_cyc[2] - acc_cyc[1] !== 36) begin
            n_bad++; $display("FAIL b2b_period got=%0d,%0d exp=36,36", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
         end
      end
      n_cmp++; if (gap_cyc !== 3) begin n_bad++; $display("FAIL b2b_gap got=%0d exp=3", gap_cyc); end
   endtask

   task automatic test_wide();
      int acc_cyc [2];
      int n_acc, n_rx, stray_cs, tog_start;
      logic pending, sel3_phase;
      logic [15:0] exp;
      tog_start = tog1;
      tx_sel1 = 2'd0; tx_data1 = 16'h8001; tx_valid1 = 1'b1; exp1_q.push_back(16'h8001);
      acc_cyc[0] = cyc; n_acc = 1; pending = 1'b1; n_rx = 0; stray_cs = 0; sel3_phase = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (c == 0) begin
            n_cmp++; if (cs_n1 !== 3'b110) begin n_bad++; $display("FAIL wide_cs0 got=%b exp=110", cs_n1); end
         end
         if (pending) begin
            if (n_acc < 2) begin tx_data1 = 16'h1234; tx_sel1 = 2'd3; exp1_q.push_back(16'h1234); end
            else begin tx_valid1 = 1'b0; sel3_phase = 1'b1; end
         end
         if (sel3_phase && cs_n1 !== 3'b111) stray_cs++;
         if (rx_valid1) begin
            n_rx++; n_cmp++;
            if (exp1_q.size() == 0) begin n_bad++; $display("FAIL wide_rx unexpected got=%h", rx_data1); end
            else begin
               exp = exp1_q.pop_front();
               $display("[%0t] wide rx=%h exp=%h", $time, rx_data1, exp);
               if (rx_data1 !== exp) begin n_bad++; $display("FAIL wide_rx got=%h exp=%h", rx_data1, exp); end
            end
         end
         pending = tx_valid1 && tx_ready1;
         if (pending && n_acc < 2) begin acc_cyc[n_acc] = cyc; n_acc++; end
         if (n_rx == 2 && tx_ready1 && !tx_valid1) break;
      end
      tx_valid1 = 1'b0;
      @(negedge clk);
      n_cmp++; if (n_acc !== 2 || acc_cyc[1] - acc_cyc[0] !== 35) begin
         n_bad++; $display("FAIL wide_period got=%0d acc=%0d exp=35", acc_cyc[1] - acc_cyc[0], n_acc);
      end
      n_cmp++; if (n_rx !== 2 || stray_cs !== 0) begin
         n_bad++; $display("FAIL wide_sel3 got=%0d rx %0d stray exp=2/0", n_rx, stray_cs);
      end
      n_cmp++; if (tog1 - tog_start !== 64) begin n_bad++; $display("FAIL wide_toggles got=%0d exp=64", tog1 - tog_start); end
   endtask

   task automatic test_reset_mid();
      int tog, rxv_seen;
      logic prev, done;
      logic [7:0] exp;
      loop0 = 1'b1; cpol0 = 1'b1; cpha0 = 1'b0; tx_sel0 = 2'd0;
      repeat (2) @(negedge clk);
      tx_data0 = 8'h96; tx_valid0 = 1'b1;
      tog = 0; prev = sclk0; done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         tx_valid0 = 1'b0;
         if (sclk0 !== prev) tog++;
         prev = sclk0;
         if (tog == 5) begin done = 1'b1; break; end
      end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rstmid_edge5 got=%0d toggles exp=5", tog); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (cs_n0 !== 4'hF || sclk0 !== 1'b0 || mosi0 !== 1'b0 || busy0 !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_async got=cs %b sclk %b mosi %b busy %b exp=1111 0 0 0", cs_n0, sclk0, mosi0, busy0);
      end
      rxv_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rx_valid0) rxv_seen++;
      end
      n_cmp++; if (rxv_seen !== 0) begin n_bad++; $display("FAIL rstmid_no_rxv got=%0d exp=0", rxv_seen); end
      rst_n = 1'b1;
      tx_data0 = 8'h69; tx_valid0 = 1'b1; exp0_q.push_back(8'h69);
      done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         tx_valid0 = 1'b0;
         if (c == 0) begin
            n_cmp++; if (cs_n0 !== 4'b1110) begin n_bad++; $display("FAIL rstmid_first_accept got=%b exp=1110", cs_n0); end
         end
         if (rx_valid0) begin
            n_cmp++;
            if (exp0_q.size() == 0) begin n_bad++; $display("FAIL rstmid_rx unexpected got=%h", rx_data0); end
            else begin
               exp = exp0_q.pop_front();
               $display("[%0t] post-reset rx=%h exp=%h", $time, rx_data0, exp);
               if (rx_data0 !== exp) begin n_bad++; $display("FAIL rstmid_rx got=%h exp=%h", rx_data0, exp); end
            end
         end
         if (tx_ready0 && c > 0) begin done = 1'b1; break; end
      end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rstmid_frame_end got=%b exp=1", done); end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_modes();
      test_cs_sel();
      test_back_to_back();
      test_wide();
      test_reset_mid();
      n_cmp++; if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
         n_bad++; $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp0_q.size(), exp1_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
